// File: rtl/uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// uart_rx_monitor : 8N1 UART receiver feeding a byte FIFO with valid/ready out.
// Define TB_UART_MON_PARITY_EN for 8E1 frames and a parity_err pulse. Rev 1.0
// ============================================================================
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic        wb_clk_o,
    input  logic        async_rst,
    input  logic        rx_line,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
`ifdef TB_UART_MON_PARITY_EN
    output logic        parity_err,
`endif
    output logic        overflow,
    output logic [15:0] byte_count
);

    localparam int                       DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0]              BIT_LOAD   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]              HALF_LOAD  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    logic        sync1, rx_s;
    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  bit_idx, idx_nx;
    logic [7:0]  shift, shift_nx;
    logic        cnt_zero;
    logic        stop_sample;
    logic        parity_ok;
    logic        push;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic                       full, pop, push_ok;

    always_ff @(posedge wb_clk_o or posedge async_rst) begin
        if (async_rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_line;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge wb_clk_o or posedge async_rst) begin
        if (async_rst) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= idx_nx;
            shift   <= shift_nx;
        end
    end

    assign cnt_zero = (cnt == 16'd0);

    // Start sample lands mid-bit; every later sample is one full bit apart.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = bit_idx;
        shift_nx    = shift;
        stop_sample = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    cnt_nx   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (!rx_s) begin
                        state_nx = DATA;
                        cnt_nx   = BIT_LOAD;
                        idx_nx   = 3'd0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_nx[bit_idx] = rx_s;
                    cnt_nx            = BIT_LOAD;
                    idx_nx            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef TB_UART_MON_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
`ifdef TB_UART_MON_PARITY_EN
            PARITY: begin
                if (cnt_zero) begin
                    cnt_nx   = BIT_LOAD;
                    state_nx = STOP;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_zero) begin
                    stop_sample = 1'b1;
                    state_nx    = WAIT_IDLE;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef TB_UART_MON_PARITY_EN
    logic par_bit;

    always_ff @(posedge wb_clk_o or posedge async_rst) begin
        if (async_rst) begin
            par_bit <= 1'b0;
        end else if (state == PARITY && cnt_zero) begin
            par_bit <= rx_s;
        end
    end

    assign parity_ok  = ~(^{shift, par_bit});
    assign parity_err = stop_sample & ~parity_ok;
`else
    assign parity_ok  = 1'b1;
`endif

    assign frame_err = stop_sample & ~rx_s;
    assign push      = stop_sample & rx_s & parity_ok;

    assign rx_valid = (count != '0);
    assign full     = (count == FULL_COUNT);
    assign pop      = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push & (~full | pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge wb_clk_o or posedge async_rst) begin
        if (async_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            byte_count <= 16'd0;
        end else begin
            if (push_ok) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                byte_count <= byte_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_o) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_monitor : directed bench for uart_rx_monitor (table + sequences).
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_monitor;

    localparam int CPB = 434;

    logic        wb_clk_o = 1'b0;
    logic        async_rst;
    logic        rx_line;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overflow;
    logic [15:0] byte_count;
`ifdef TB_UART_MON_PARITY_EN
    logic        parity_err;
`endif

    int total = 0;
    int bad   = 0;
    int ferr_pulses = 0;
    int perr_pulses = 0;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        exp_valid;
        logic [7:0]  exp_data;
        int          exp_ferr;
        logic [15:0] exp_count;
    } vec_t;

    uart_rx_monitor #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (3)
    ) dut (
        .wb_clk_o   (wb_clk_o),
        .async_rst  (async_rst),
        .rx_line    (rx_line),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
`ifdef TB_UART_MON_PARITY_EN
        .parity_err (parity_err),
`endif
        .overflow   (overflow),
        .byte_count (byte_count)
    );

    always #5 wb_clk_o = ~wb_clk_o;

    always @(negedge wb_clk_o) begin
        if (frame_err === 1'b1) ferr_pulses++;
`ifdef TB_UART_MON_PARITY_EN
        if (parity_err === 1'b1) perr_pulses++;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge wb_clk_o);
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        idle(CPB);
    endtask

    // Even parity bit is only put on the wire in the 8E1 build.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef TB_UART_MON_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) rx_line = 1'b1;
`endif
        send_bit(stop);
        rx_line = 1'b1;
        idle(4);
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        async_rst = 1'b1;
        idle(3);
        async_rst = 1'b0;
        idle(2);
    endtask

    initial begin
        vec_t vecs[4];
        int   f0;
        int   cyc;

        vecs[0] = '{8'hA3, 1'b0, 1'b0, 8'h00, 1, 16'd1};
        vecs[1] = '{8'h41, 1'b1, 1'b1, 8'h41, 0, 16'd2};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 0, 16'd3};
        vecs[3] = '{8'hC8, 1'b0, 1'b0, 8'h00, 1, 16'd3};

        async_rst = 1'b1;
        rx_line   = 1'b1;
        rx_ready  = 1'b0;
        idle(3);
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_data", {24'd0, rx_data}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        chk("reset_count", {16'd0, byte_count}, 32'd0);
        async_rst = 1'b0;
        idle(2);

        // First byte: bounded wait for rx_valid from the start edge.
        cyc = 0;
        fork
            send_frame(8'h55, 1'b0, 1'b1);
            begin
                while (rx_valid !== 1'b1 && cyc < 5000) begin
                    @(negedge wb_clk_o);
                    cyc++;
                end
            end
        join
        chk("first_latency_ok", {31'd0, cyc <= 10 * CPB + 4}, 32'd1);
        chk("first_valid", {31'd0, rx_valid}, 32'd1);
        chk("first_count", {16'd0, byte_count}, 32'd1);
        pop_chk("first_data", 8'h55);
        chk("first_empty", {31'd0, rx_valid}, 32'd0);

        // 100-cycle low glitch must not start a frame.
        f0 = ferr_pulses;
        rx_line = 1'b0;
        idle(100);
        rx_line = 1'b1;
        idle(CPB);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
        chk("glitch_ferr", ferr_pulses - f0, 32'd0);
        chk("glitch_count", {16'd0, byte_count}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            f0 = ferr_pulses;
            send_frame(vecs[i].data, ^vecs[i].data, vecs[i].stop);
            chk($sformatf("vec%0d_valid", i), {31'd0, rx_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_ferr", i), ferr_pulses - f0, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_count", i), {16'd0, byte_count}, {16'd0, vecs[i].exp_count});
            if (vecs[i].exp_valid) begin
                rx_ready = 1'b1;
                idle(1);
                rx_ready = 1'b0;
            end
        end

        // Nine bytes into an eight-entry FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 9; i++) send_frame(8'(i), ^(8'(i)), 1'b1);
        chk("ovf_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {16'd0, byte_count}, 32'd8);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("ovf_pop%0d", i), 8'(i));
        chk("ovf_drained", {31'd0, rx_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Leave a byte queued, then reset asynchronously in data bit 4 of 0xFF.
        send_frame(8'h5A, 1'b0, 1'b1);
        chk("pre_rst_count", {16'd0, byte_count}, 32'd9);
        chk("pre_rst_data", {24'd0, rx_data}, 32'h5A);
        rx_line = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_line = 1'b1;
        idle(CPB / 2);
        #2 async_rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst_data", {24'd0, rx_data}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow}, 32'd0);
        chk("midrst_count", {16'd0, byte_count}, 32'd0);
        idle(3);
        async_rst = 1'b0;
        idle(CPB);
        f0 = ferr_pulses;
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("post_rst_valid", {31'd0, rx_valid}, 32'd1);
        chk("post_rst_count", {16'd0, byte_count}, 32'd1);
        chk("post_rst_ferr", ferr_pulses - f0, 32'd0);
        pop_chk("post_rst_data", 8'h3C);

`ifdef TB_UART_MON_PARITY_EN
        f0 = perr_pulses;
        send_frame(8'h07, 1'b1, 1'b1);
        chk("par_good_valid", {31'd0, rx_valid}, 32'd1);
        chk("par_good_perr", perr_pulses - f0, 32'd0);
        chk("par_good_count", {16'd0, byte_count}, 32'd2);
        pop_chk("par_good_data", 8'h07);
        f0 = perr_pulses;
        cyc = ferr_pulses;
        send_frame(8'h07, 1'b0, 1'b1);
        chk("par_bad_valid", {31'd0, rx_valid}, 32'd0);
        chk("par_bad_perr", perr_pulses - f0, 32'd1);
        chk("par_bad_ferr", ferr_pulses - cyc, 32'd0);
        chk("par_bad_count", {16'd0, byte_count}, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
